// File: rtl/fc_pkg.sv
// Shared constants, state encoding and saturation helper for the FC forward engine.
// Build option: FC_RELU_EN enables ReLU on the hidden-layer finalize.
package fc_pkg;
  localparam int FRT_CELL  = 32;
  localparam int MID_CELL  = 20;
  localparam int BCK_CELL  = 10;
  localparam int FRAC_BITS = 10;
  localparam int IDX_W     = 5;

  localparam logic signed [15:0] FX_ONE = 16'sh0400;
  localparam logic signed [15:0] FX_MAX = 16'sh7FFF;
  localparam logic signed [15:0] FX_MIN = 16'sh8000;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE, LD_IN, MAC1, WR1, MAC2, WR2, WR_LBL, BWD
  } fc_state_t;

  // Rescale a Q-format accumulator back to 16 bits, clamping instead of wrapping.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] a);
    logic signed [31:0] s;
    s = a >>> FRAC_BITS;
    if (s > 32'sd32767) return FX_MAX;
    if (s < -32'sd32768) return FX_MIN;
    return s[15:0];
  endfunction
endpackage

// File: rtl/fc_forward_engine_if.sv
// FC memory port: engine drives we/addr/data, memory returns read data one cycle after addr.
interface fc_mem_if;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_rdata;

  modport master (output mem_we, output mem_addr, output mem_data, input mem_rdata);
  modport slave  (input mem_we, input mem_addr, input mem_data, output mem_rdata);
endinterface

// File: rtl/fc_mac.sv
// Shared multiply-accumulate: 16x16 signed products into a 32-bit accumulator,
// with a combinational finalize (shift, saturate, optional ReLU) on the row's last element.
module fc_mac
  import fc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear,
  input  logic               relu,
  input  logic signed [15:0] x,
  input  logic signed [15:0] w,
  output logic signed [15:0] result
);
  logic signed [31:0] acc;
  logic signed [31:0] prod;
  logic signed [31:0] sum;

  // Low 32 bits of the extended product equal the signed product.
  assign prod = {{16{x[15]}}, x} * {{16{w[15]}}, w};
  assign sum  = (clear ? 32'sd0 : acc) + prod;

  always_comb begin
    result = sat16(sum);
    if (relu && result[15]) result = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (en) acc <= sum;
  end
endmodule

// File: rtl/fc_forward_engine.sv
// Two-layer FC forward sequencer: loads inputs, runs both MAC layers, writes results
// and the one-hot target, then hands off to back-prop. Build option: FC_RELU_EN.
module fc_forward_engine
  import fc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] label,
  fc_mem_if.master   mem,
  output logic       fc1_com_end,
  output logic       fc2_com_end,
  output logic       bck_prop_start,
  input  logic       fc_bck_prop_end,
  output logic [3:0] pred_class,
  output logic       busy,
  output logic       done,
  output fc_state_t  dbg_state
);
  fc_state_t          state;
  logic [15:0]        cnt;
  idx_t               col, row;
  logic [3:0]         label_q;
  logic signed [15:0] in_buf  [FRT_CELL];
  logic signed [15:0] mid_buf [MID_CELL];
  logic signed [15:0] out_buf [BCK_CELL];

  logic               mac_en, mac_clr, mac_last, mac_relu;
  logic signed [15:0] mac_x, mac_res, best;
  logic [3:0]         amax;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Read data lags the address by one cycle, so col/row track the element being consumed.
  assign mac_en   = ((state == MAC1) || (state == MAC2)) && (cnt != 16'd0);
  assign mac_x    = (state == MAC1) ? in_buf[col] : mid_buf[col];
  assign mac_clr  = (col == '0);
  assign mac_last = (state == MAC1) ? (col == idx_t'(FRT_CELL - 1)) : (col == idx_t'(MID_CELL - 1));
`ifdef FC_RELU_EN
  assign mac_relu = (state == MAC1);
`else
  assign mac_relu = 1'b0;
`endif

  fc_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .en     (mac_en),
    .clear  (mac_clr),
    .relu   (mac_relu),
    .x      (mac_x),
    .w      (mem.mem_rdata),
    .result (mac_res)
  );

  always_comb begin
    amax = '0;
    best = out_buf[0];
    for (int b = 1; b < BCK_CELL; b++) begin
      if (out_buf[b] > best) begin
        best = out_buf[b];
        amax = 4'(b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      col            <= '0;
      row            <= '0;
      label_q        <= '0;
      mem.mem_we     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_data   <= '0;
      fc1_com_end    <= 1'b0;
      fc2_com_end    <= 1'b0;
      bck_prop_start <= 1'b0;
      pred_class     <= '0;
      done           <= 1'b0;
      for (int i = 0; i < FRT_CELL; i++) in_buf[i]  <= '0;
      for (int i = 0; i < MID_CELL; i++) mid_buf[i] <= '0;
      for (int i = 0; i < BCK_CELL; i++) out_buf[i] <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + 16'd1;
      if (mac_en) begin
        if (mac_last) begin
          if (state == MAC1) mid_buf[row] <= mac_res;
          else out_buf[row[3:0]] <= mac_res;
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        IDLE: if (start) begin
          state        <= LD_IN;
          label_q      <= label;
          cnt          <= '0;
          col          <= '0;
          mem.mem_addr <= '0;
        end
        LD_IN: begin
          mem.mem_addr <= mem.mem_addr + 16'd1;
          if (cnt != 16'd0) begin
            in_buf[col] <= mem.mem_rdata;
            col         <= col + 1'b1;
          end
          if (cnt == 16'(FRT_CELL)) begin
            state        <= MAC1;
            cnt          <= '0;
            col          <= '0;
            row          <= '0;
            mem.mem_addr <= 16'(FRT_CELL);
          end
        end
        MAC1, MAC2: begin
          mem.mem_addr <= mem.mem_addr + 16'd1;
          if ((state == MAC1 && cnt == 16'(MID_CELL * FRT_CELL)) ||
              (state == MAC2 && cnt == 16'(BCK_CELL * MID_CELL))) begin
            state        <= (state == MAC1) ? WR1 : WR2;
            col          <= idx_t'(1);
            mem.mem_we   <= 1'b1;
            mem.mem_addr <= '0;
            mem.mem_data <= (state == MAC1) ? mid_buf[0] : out_buf[0];
            if (state == MAC1) fc1_com_end <= 1'b1;
            else fc2_com_end <= 1'b1;
          end
        end
        WR1: begin
          if (col == idx_t'(MID_CELL)) begin
            state        <= MAC2;
            cnt          <= '0;
            col          <= '0;
            row          <= '0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= 16'(MID_CELL);
          end else begin
            mem.mem_addr <= 16'(col);
            mem.mem_data <= mid_buf[col];
            col          <= col + 1'b1;
          end
        end
        WR2: begin
          if (col == idx_t'(BCK_CELL)) begin
            state        <= WR_LBL;
            pred_class   <= amax;
            col          <= idx_t'(1);
            mem.mem_addr <= 16'(BCK_CELL);
            mem.mem_data <= (label_q == 4'd0) ? FX_ONE : '0;
          end else begin
            mem.mem_addr <= 16'(col);
            mem.mem_data <= out_buf[col[3:0]];
            col          <= col + 1'b1;
          end
        end
        WR_LBL: begin
          if (col == idx_t'(BCK_CELL)) begin
            state          <= BWD;
            mem.mem_we     <= 1'b0;
            bck_prop_start <= 1'b1;
          end else begin
            mem.mem_addr <= 16'(BCK_CELL) + 16'(col);
            mem.mem_data <= ({1'b0, label_q} == col) ? FX_ONE : '0;
            col          <= col + 1'b1;
          end
        end
        BWD: if (fc_bck_prop_end) begin
          state          <= IDLE;
          bck_prop_start <= 1'b0;
          fc1_com_end    <= 1'b0;
          fc2_com_end    <= 1'b0;
          done           <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_forward_engine.sv
// Bench for fc_forward_engine: banked FC memory model, table vectors, random passes vs a reference model.
module tb_fc_forward_engine;
  import fc_pkg::*;

  localparam bit RELU =
`ifdef FC_RELU_EN
    1'b1;
`else
    1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, start, fc_bck_prop_end;
  logic [3:0] label;
  logic fc1_com_end, fc2_com_end, bck_prop_start, busy, done;
  logic [3:0] pred_class;
  fc_state_t dbg_state;
  always #5 clk = ~clk;

  fc_mem_if mem_bus ();

  fc_forward_engine dut (
    .clk(clk), .reset(reset), .start(start), .label(label), .mem(mem_bus),
    .fc1_com_end(fc1_com_end), .fc2_com_end(fc2_com_end), .bck_prop_start(bck_prop_start),
    .fc_bck_prop_end(fc_bck_prop_end), .pred_class(pred_class), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- banked memory model ----------------
  logic [15:0] mem_arr [3][1024];
  int bank_sel;
  assign bank_sel = fc2_com_end ? 2 : (fc1_com_end ? 1 : 0);
  always @(posedge clk) begin
    if (mem_bus.mem_we) mem_arr[bank_sel][mem_bus.mem_addr[9:0]] <= mem_bus.mem_data;
    mem_bus.mem_rdata <= mem_arr[bank_sel][mem_bus.mem_addr[9:0]];
  end

  int we_bad = 0;
  always @(negedge clk) begin
    if (!reset && mem_bus.mem_we &&
        !(dbg_state == WR1 || dbg_state == WR2 || dbg_state == WR_LBL || bank_sel == 0)) we_bad++;
    if (!reset && mem_bus.mem_we && bank_sel == 0) we_bad++;
  end

  // ---------------- scoreboard ----------------
  int compared = 0, mismatched = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- data and reference model ----------------
  int in_v [FRT_CELL];
  int w1 [MID_CELL][FRT_CELL];
  int w2 [BCK_CELL][MID_CELL];

  function automatic int fx_fin(input longint s);
    longint t;
    t = s >>> FRAC_BITS;
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return int'(t);
  endfunction

  task automatic push_target(input logic [3:0] lbl);
    for (int b = 0; b < BCK_CELL; b++) exp_q.push_back((b == int'(lbl)) ? 16'h0400 : 16'h0000);
  endtask

  // Pushes hidden, outputs, target and predicted class computed from the layer equations.
  task automatic model(input logic [3:0] lbl);
    int h [MID_CELL];
    int o [BCK_CELL];
    int best;
    longint s;
    for (int m = 0; m < MID_CELL; m++) begin
      s = 0;
      for (int f = 0; f < FRT_CELL; f++) s += longint'(in_v[f]) * longint'(w1[m][f]);
      h[m] = fx_fin(s);
      if (RELU && h[m] < 0) h[m] = 0;
      exp_q.push_back(16'(h[m]));
    end
    best = 0;
    for (int b = 0; b < BCK_CELL; b++) begin
      s = 0;
      for (int m = 0; m < MID_CELL; m++) s += longint'(h[m]) * longint'(w2[b][m]);
      o[b] = fx_fin(s);
      exp_q.push_back(16'(o[b]));
      if (o[b] > o[best]) best = b;
    end
    push_target(lbl);
    exp_q.push_back(16'(best));
  endtask

  task automatic load_mem();
    for (int f = 0; f < FRT_CELL; f++) mem_arr[0][f] = 16'(in_v[f]);
    for (int m = 0; m < MID_CELL; m++)
      for (int f = 0; f < FRT_CELL; f++) mem_arr[0][FRT_CELL + m*FRT_CELL + f] = 16'(w1[m][f]);
    for (int b = 0; b < BCK_CELL; b++)
      for (int m = 0; m < MID_CELL; m++) mem_arr[1][MID_CELL + b*MID_CELL + m] = 16'(w2[b][m]);
    for (int m = 0; m < MID_CELL; m++) mem_arr[1][m] = 16'hDEAD;
    for (int b = 0; b < 2*BCK_CELL; b++) mem_arr[2][b] = 16'hDEAD;
  endtask

  task automatic load_uniform(input logic [15:0] iv, input logic [15:0] w1v, input logic [15:0] w2v);
    for (int f = 0; f < FRT_CELL; f++) in_v[f] = int'($signed(iv));
    for (int m = 0; m < MID_CELL; m++)
      for (int f = 0; f < FRT_CELL; f++) w1[m][f] = int'($signed(w1v));
    for (int b = 0; b < BCK_CELL; b++)
      for (int m = 0; m < MID_CELL; m++) w2[b][m] = int'($signed(w2v));
    load_mem();
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_pass(input logic [3:0] lbl, input int bwd_hold, input bit poke_start);
    int n, stuck;
    @(negedge clk); start = 1'b1; label = lbl;
    @(negedge clk); start = 1'b0; label = 4'd0;
    chk("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (!bck_prop_start && n < 3000) begin @(negedge clk); n++; end
    chk("reach_bwd", 32'(bck_prop_start), 32'd1);
    if (!bck_prop_start) return;
    stuck = 0;
    for (int i = 0; i < bwd_hold; i++) begin
      start = (poke_start && i == bwd_hold/2);
      @(negedge clk);
      if (!bck_prop_start || dbg_state != BWD || mem_bus.mem_we) stuck++;
    end
    start = 1'b0;
    chk("bwd_hold", 32'(stuck), 32'd0);
    fc_bck_prop_end = 1'b1;
    @(negedge clk);
    fc_bck_prop_end = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("bwd_exit_levels", {28'd0, bck_prop_start, fc1_com_end, fc2_com_end, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic check_results(input string tag);
    for (int m = 0; m < MID_CELL; m++)
      chk($sformatf("%s_hidden%0d", tag, m), 32'(mem_arr[1][m]), 32'(exp_q.pop_front()));
    for (int b = 0; b < BCK_CELL; b++)
      chk($sformatf("%s_out%0d", tag, b), 32'(mem_arr[2][b]), 32'(exp_q.pop_front()));
    for (int b = 0; b < BCK_CELL; b++)
      chk($sformatf("%s_target%0d", tag, b), 32'(mem_arr[2][BCK_CELL + b]), 32'(exp_q.pop_front()));
    chk($sformatf("%s_pred", tag), 32'(pred_class), 32'(exp_q.pop_front()));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_data[8:0], fc1_com_end,
              fc2_com_end, bck_prop_start, pred_class[0], busy, done},
        32'd0);
    chk({tag, "_pred"}, 32'(pred_class), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] in_val, w1_val, w2_val;
    logic [3:0]  lbl;
    logic [15:0] exp_h, exp_o;
    logic [3:0]  exp_pred;
  } vec_t;
  vec_t vecs [5];

  initial begin
    reset = 1'b1; start = 1'b0; label = 4'd0; fc_bck_prop_end = 1'b0;
    for (int b = 0; b < 3; b++) for (int a = 0; a < 1024; a++) mem_arr[b][a] = 16'h0000;

    vecs[0] = '{16'h0400, 16'h0040, 16'h0040, 4'd0, 16'h0800, 16'h0A00, 4'd0};
    vecs[1] = '{16'h0400, 16'h0040, 16'h0400, 4'd5, 16'h0800, 16'h7FFF, 4'd0};
    vecs[2] = '{16'h0400, 16'hFFC0, 16'h0040, 4'd3,
                RELU ? 16'h0000 : 16'hF800, RELU ? 16'h0000 : 16'hF600, 4'd0};
    vecs[3] = '{16'h0000, 16'h1234, 16'h0400, 4'd9, 16'h0000, 16'h0000, 4'd0};
    vecs[4] = '{16'h0400, 16'h0400, 16'hFC00, 4'd12, 16'h7FFF, 16'h8000, 4'd0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load_uniform(vecs[i].in_val, vecs[i].w1_val, vecs[i].w2_val);
      for (int m = 0; m < MID_CELL; m++) exp_q.push_back(vecs[i].exp_h);
      for (int b = 0; b < BCK_CELL; b++) exp_q.push_back(vecs[i].exp_o);
      push_target(vecs[i].lbl);
      exp_q.push_back(16'(vecs[i].exp_pred));
      run_pass(vecs[i].lbl, (i == 0) ? 50 : 2, i == 0);
      check_results($sformatf("vec%0d", i));
    end

    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < FRT_CELL; f++) in_v[f] = int'($urandom_range(0, 4095)) - 2048;
      for (int m = 0; m < MID_CELL; m++)
        for (int f = 0; f < FRT_CELL; f++) w1[m][f] = int'($urandom_range(0, 511)) - 256;
      for (int b = 0; b < BCK_CELL; b++)
        for (int m = 0; m < MID_CELL; m++) w2[b][m] = int'($urandom_range(0, 511)) - 256;
      load_mem();
      label = 4'($urandom_range(0, 15));
      model(label);
      run_pass(label, int'($urandom_range(0, 8)), 1'b0);
      check_results($sformatf("rand%0d", r));
    end

    // Abort in the middle of the first layer, then confirm a clean rerun.
    load_uniform(vecs[0].in_val, vecs[0].w1_val, vecs[0].w2_val);
    @(negedge clk); start = 1'b1; label = 4'd1;
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_mac1_state", 32'(dbg_state), 32'(MAC1));
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_mid_mac1");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(dbg_state), 32'(IDLE));
    for (int m = 0; m < MID_CELL; m++) exp_q.push_back(vecs[0].exp_h);
    for (int b = 0; b < BCK_CELL; b++) exp_q.push_back(vecs[0].exp_o);
    push_target(4'd7);
    exp_q.push_back(16'(vecs[0].exp_pred));
    run_pass(4'd7, 3, 1'b0);
    check_results("after_reset");

    chk("mem_we_only_in_write_states", 32'(we_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
